imm_gen_pipe: RTL and testbench

//  ID-stage immediate unit, successor to the combinational immediate generator.

---
 rtl/rv_imm_pkg.sv | 24 ++
 rtl/imm_skid_buf.sv | 59 +++++
 rtl/imm_gen_pipe.sv | 116 +++++++++++
 tb/tb_imm_gen_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_imm_pkg.sv
// Shared opcode constants and immediate-format codes for the ID-stage immediate unit.
package rv_imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_ILL
  } imm_fmt_e;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; out_* always come from the main entry.
module imm_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Valid/ready: a beat moves on a side exactly when valid && ready at the rising edge;
  // a producer holding valid keeps its data stable until that edge, and the consumer
  // side never withdraws out_valid or changes out_data until the beat is taken.
  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         main_free;

  assign in_ready  = SKID_EN ? !skid_valid : (out_ready || !main_valid);
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // A full skid always refills main first; in_ready is low then, so nothing else arrives.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_data <= in_data;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate unit: combinational RV32I/RV64I immediate decode feeding a registered skid stage.
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam bit RV64 = (XLEN == 64);
  localparam int W    = 2 * XLEN + 4;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [W-1:0]    buf_in;
  logic [W-1:0]    buf_out;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILL;
    case (opcode)
      OP_IMM, OP_IMM32: begin
        if (opcode == OP_IMM32 && !RV64) begin
          dec_fmt = FMT_ILL;
        end else if (is_shift(funct3)) begin
          // Shift amounts are unsigned; bit 25 only counts for 64-bit shifts of full-width regs.
          dec_fmt      = FMT_SH;
          dec_imm[4:0] = in_inst[24:20];
          if (RV64 && opcode == OP_IMM) dec_imm[5] = in_inst[25];
        end else begin
          dec_fmt = FMT_I;
          dec_imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0});
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = sext32({in_inst[31:12], 12'b0});
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0});
      end
      OP_REG:   dec_fmt = FMT_R;
      OP_REG32: dec_fmt = RV64 ? FMT_R : FMT_ILL;
      default:  dec_fmt = FMT_ILL;
    endcase
  end

  assign dec_illegal = (dec_fmt == FMT_ILL);
  assign buf_in      = {in_pc, dec_illegal, dec_fmt, dec_imm};

  imm_skid_buf #(
    .W       (W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_imm     = buf_out[XLEN-1:0];
  assign out_fmt     = buf_out[XLEN+2:XLEN];
  assign out_illegal = buf_out[XLEN+3];
  assign out_pc      = buf_out[W-1:XLEN+4];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed decode/handshake steps plus a random stream scored against a reference model.
module tb_imm_gen_pipe;
  import rv_imm_pkg::*;

  localparam int XLEN = 32;
  localparam int DW   = 2 * XLEN + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst   = '0;
  logic [XLEN-1:0] in_pc     = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  // 64-bit instance, always drained
  logic            in_valid64 = 1'b0;
  logic            in_ready64;
  logic [31:0]     in_inst64  = '0;
  logic [63:0]     in_pc64    = '0;
  logic            out_valid64;
  logic [63:0]     out_imm64;
  logic [2:0]      out_fmt64;
  logic [63:0]     out_pc64;
  logic            out_illegal64;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [DW-1:0] exp_q[$];

  imm_gen_pipe #(.XLEN(XLEN), .SKID_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_pc(out_pc64), .out_illegal(out_illegal64)
  );

  // ---------------- reference model ----------------
  function automatic longint fld(input logic [31:0] w, input int lo, input int n);
    logic [31:0] m;
    m = (32'd1 << n) - 32'd1;
    return longint'((w >> lo) & m);
  endfunction

  function automatic void ref_dec(input logic [31:0] inst, input int xlen,
                                  output longint imm, output imm_fmt_e fmt);
    int     op;
    int     f3;
    longint neg;
    op  = int'(fld(inst, 0, 7));
    f3  = int'(fld(inst, 12, 3));
    neg = fld(inst, 31, 1);
    imm = 0;
    fmt = FMT_ILL;
    if ((op == 'h13 || (op == 'h1b && xlen == 64)) && (f3 == 1 || f3 == 5)) begin
      fmt = FMT_SH;
      imm = (xlen == 32 || op == 'h1b) ? fld(inst, 20, 5) : fld(inst, 20, 6);
    end else if (op == 'h03 || op == 'h13 || op == 'h67 || (op == 'h1b && xlen == 64)) begin
      fmt = FMT_I;
      imm = fld(inst, 20, 12) - 4096 * neg;
    end else if (op == 'h23) begin
      fmt = FMT_S;
      imm = fld(inst, 25, 7) * 32 + fld(inst, 7, 5) - 4096 * neg;
    end else if (op == 'h63) begin
      fmt = FMT_B;
      imm = fld(inst, 7, 1) * 2048 + fld(inst, 25, 6) * 32 + fld(inst, 8, 4) * 2 - 4096 * neg;
    end else if (op == 'h37 || op == 'h17) begin
      fmt = FMT_U;
      imm = fld(inst, 12, 20) * 4096 - (longint'(1) << 32) * neg;
    end else if (op == 'h6f) begin
      fmt = FMT_J;
      imm = fld(inst, 12, 8) * 4096 + fld(inst, 20, 1) * 2048 + fld(inst, 21, 10) * 2
            - 1048576 * neg;
    end else if (op == 'h33 || (op == 'h3b && xlen == 64)) begin
      fmt = FMT_R;
    end
  endfunction

  function automatic logic [DW-1:0] model(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    longint          imm;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] t;
    ref_dec(inst, XLEN, imm, fmt);
    t = imm[XLEN-1:0];
    return {pc, (fmt == FMT_ILL), fmt, t};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 12))
      0:       r[6:0] = 7'h03;
      1:       r[6:0] = 7'h13;
      2:       r[6:0] = 7'h13;
      3:       r[6:0] = 7'h67;
      4:       r[6:0] = 7'h23;
      5:       r[6:0] = 7'h63;
      6:       r[6:0] = 7'h37;
      7:       r[6:0] = 7'h17;
      8:       r[6:0] = 7'h6f;
      9:       r[6:0] = 7'h33;
      10:      r[6:0] = 7'h1b;
      11:      r[6:0] = 7'h3b;
      default: r[6:0] = 7'h7f;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0] prev_obs  = '0;
  logic          hold_prev = 1'b0;
  logic          flush_prev = 1'b0;

  always @(negedge clk) begin : monitor
    logic [DW-1:0] obs;
    logic [DW-1:0] exp;
    obs = {out_pc, out_illegal, out_fmt, out_imm};
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && !flush_prev) begin
        checks++;
        assert (out_valid === 1'b1 && obs === prev_obs) else begin
          failures++;
          $error("FAIL hold_stable observed=%0h valid=%0b expected=%0h", obs, out_valid, prev_obs);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else exp = 'x;
        assert (obs === exp) else begin
          failures++;
          $error("FAIL out_beat observed=%0h expected=%0h", obs, exp);
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_inst, in_pc));
      hold_prev  = out_valid && !out_ready;
      flush_prev = flush;
      prev_obs   = obs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] inst);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = $urandom;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_timeout", (n < 50), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic dir(input string tag, input logic [31:0] inst,
                     input logic [XLEN-1:0] e_imm, input imm_fmt_e e_fmt);
    logic [XLEN-1:0] pc;
    send(inst);
    pc = in_pc;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_imm"}, out_imm, e_imm);
    chk({tag, "_fmt"}, out_fmt, e_fmt);
    chk({tag, "_ill"}, out_illegal, (e_fmt == FMT_ILL));
    chk({tag, "_pc"}, out_pc, pc);
  endtask

  task automatic send64(input string tag, input logic [31:0] inst);
    longint      imm;
    imm_fmt_e    fmt;
    logic [63:0] e_imm;
    logic [63:0] pc;
    ref_dec(inst, 64, imm, fmt);
    e_imm      = imm;
    pc         = {$urandom, $urandom};
    in_valid64 = 1'b1;
    in_inst64  = inst;
    in_pc64    = pc;
    chk({tag, "_rdy"}, in_ready64, 1);
    tick();
    in_valid64 = 1'b0;
    chk({tag, "_valid"}, out_valid64, 1);
    chk({tag, "_imm"}, out_imm64, e_imm);
    chk({tag, "_fmt"}, out_fmt64, fmt);
    chk({tag, "_ill"}, out_illegal64, (fmt == FMT_ILL));
    chk({tag, "_pc"}, out_pc64, pc);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    int   n0;
    logic held;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_fmt", out_fmt, FMT_R);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ill", out_illegal, 0);

    dir("addi", 32'hFFF00093, 32'hFFFFFFFF, FMT_I);
    dir("srai", 32'h4030D093, 32'h00000003, FMT_SH);
    dir("lui",  32'h12345037, 32'h12345000, FMT_U);
    dir("jal",  32'h0040006F, 32'h00000004, FMT_J);
    dir("beq",  32'hFE000EE3, 32'hFFFFFFFC, FMT_B);
    dir("ill7f", 32'h0000007F, 32'h00000000, FMT_ILL);
    dir("sw",   32'hFE112E23, 32'hFFFFFFFC, FMT_S);
    dir("addiw32", 32'h0010009B, 32'h00000000, FMT_ILL);
    tick();

    // stall: two accepts fill main+skid, then in_ready drops
    n0        = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = rand_inst();
    in_pc     = $urandom;
    tick();
    in_inst   = rand_inst();
    in_pc     = $urandom;
    tick();
    chk("stall_in_ready_low", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    tick();
    chk("stall_still_low", in_ready, 0);
    out_ready = 1'b1;
    send(rand_inst());
    send(rand_inst());
    send(rand_inst());
    repeat (4) tick();
    chk("stall_count", n_out - n0, 5);
    chk("stall_q_empty", exp_q.size(), 0);

    // flush with main+skid full and a pending input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = rand_inst();
    tick();
    in_inst   = rand_inst();
    tick();
    chk("flush_pre_full", in_ready, 0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    n0        = n_out;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_nothing_out", n_out - n0, 0);

    // flush drops an input accepted in the same cycle
    out_ready = 1'b0;
    send(rand_inst());
    in_valid = 1'b1;
    in_inst  = rand_inst();
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_acc_out_valid", out_valid, 0);
    chk("flush_acc_in_ready", in_ready, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle_out_valid", out_valid, 0);
    chk("flush_idle_in_ready", in_ready, 1);

    // async reset mid-stream
    in_valid = 1'b1;
    in_inst  = rand_inst();
    in_pc    = $urandom;
    tick();
    in_inst  = rand_inst();
    tick();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_imm", out_imm, 0);
    chk("arst_out_fmt", out_fmt, FMT_R);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_out_ill", out_illegal, 0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    dir("post_rst_lui", 32'h12345037, 32'h12345000, FMT_U);
    tick();

    // 64-bit decode
    send64("addi64", 32'hFFF00093);
    chk("addi64_const", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    send64("slli63", 32'h03F09093);
    chk("slli63_const", out_imm64, 64'd63);
    send64("sraiw64", 32'h4210D09B);
    chk("sraiw64_const", out_imm64, 64'd1);
    send64("addiw64", 32'hFFF0009B);
    send64("subw64", 32'h4020803B);
    for (int i = 0; i < 20; i++) send64("rnd64", rand_inst());

    // random stream with backpressure and occasional flush
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = rand_inst();
        in_pc    = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      held      = in_valid && !in_ready && !flush;
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_q_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
